// File: rtl/biriscv_branch_queue.sv
// Branch outcome queue between execute and predictor training.
// Absorbs training stalls; counts overflow drops and flags malformed requests.
module biriscv_branch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       branch_request_i,
    input  logic                       branch_is_taken_i,
    input  logic                       branch_is_not_taken_i,
    input  logic [31:0]                branch_source_i,
    input  logic [31:0]                branch_pc_i,
    input  logic                       branch_is_call_i,
    input  logic                       branch_is_ret_i,
    input  logic                       branch_is_jmp_i,
    input  logic                       flush_i,
    input  logic                       train_accept_i,
    output logic                       train_valid_o,
    output logic                       train_taken_o,
    output logic [31:0]                train_source_o,
    output logic [31:0]                train_pc_o,
    output logic                       train_call_o,
    output logic                       train_ret_o,
    output logic                       train_jmp_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic [CNT_W-1:0]           drop_count_o,
    output logic                       error_o
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0]    PTR_ONE = PW'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [67:0]      mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CNT_W-1:0] drop_cnt;
    logic             err_q;

    logic        well_formed;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        drop;
    logic        bad;
    logic [67:0] head;

    // Occupancy decode and per-cycle push/pop/drop/error decisions
    always_comb begin
        well_formed = branch_is_taken_i ^ branch_is_not_taken_i;
        empty       = (rd_ptr == wr_ptr);
        full        = (rd_ptr[IW-1:0] == wr_ptr[IW-1:0]) &&
                      (rd_ptr[IW] != wr_ptr[IW]);
        pop         = ~empty & train_accept_i & ~flush_i;
        push        = branch_request_i & well_formed & ~flush_i &
                      (~full | pop);
        drop        = branch_request_i & well_formed & ~flush_i &
                      full & ~pop;
        bad         = branch_request_i & ~well_formed & ~flush_i;
    end

    // Read/write pointers; flush empties the queue
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Entry storage, written at the tail; contents are don't-care when empty
    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr[IW-1:0]] <= {branch_is_taken_i, branch_is_call_i,
                                    branch_is_ret_i, branch_is_jmp_i,
                                    branch_source_i, branch_pc_i};
    end

    // Saturating overflow counter and sticky malformed-request flag
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (drop && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_ONE;
            if (bad)
                err_q <= 1'b1;
        end
    end

    // Head presentation; fields forced low when empty, type flags need taken
    always_comb begin
        head           = mem[rd_ptr[IW-1:0]];
        train_valid_o  = ~empty;
        train_taken_o  = ~empty & head[67];
        train_call_o   = train_taken_o & head[66];
        train_ret_o    = train_taken_o & head[65];
        train_jmp_o    = train_taken_o & head[64];
        train_source_o = {32{~empty}} & head[63:32];
        train_pc_o     = {32{~empty}} & head[31:0];
        full_o         = full;
        level_o        = wr_ptr - rd_ptr;
        drop_count_o   = drop_cnt;
        error_o        = err_q;
    end

endmodule

// File: tb/tb_biriscv_branch_queue.sv
// Scoreboard bench for biriscv_branch_queue: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_biriscv_branch_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = 2;
    localparam int MAXD  = (1 << CNT_W) - 1;

    typedef struct {
        logic        tk;
        logic        call;
        logic        ret;
        logic        jmp;
        logic [31:0] src;
        logic [31:0] pc;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        branch_request_i = 1'b0;
    logic        branch_is_taken_i = 1'b0;
    logic        branch_is_not_taken_i = 1'b0;
    logic [31:0] branch_source_i = '0;
    logic [31:0] branch_pc_i = '0;
    logic        branch_is_call_i = 1'b0;
    logic        branch_is_ret_i = 1'b0;
    logic        branch_is_jmp_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        train_accept_i = 1'b0;
    logic        train_valid_o;
    logic        train_taken_o;
    logic [31:0] train_source_o;
    logic [31:0] train_pc_o;
    logic        train_call_o;
    logic        train_ret_o;
    logic        train_jmp_o;
    logic        full_o;
    logic [2:0]  level_o;
    logic [CNT_W-1:0] drop_count_o;
    logic        error_o;

    biriscv_branch_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .branch_request_i(branch_request_i),
        .branch_is_taken_i(branch_is_taken_i),
        .branch_is_not_taken_i(branch_is_not_taken_i),
        .branch_source_i(branch_source_i),
        .branch_pc_i(branch_pc_i),
        .branch_is_call_i(branch_is_call_i),
        .branch_is_ret_i(branch_is_ret_i),
        .branch_is_jmp_i(branch_is_jmp_i),
        .flush_i(flush_i),
        .train_accept_i(train_accept_i),
        .train_valid_o(train_valid_o),
        .train_taken_o(train_taken_o),
        .train_source_o(train_source_o),
        .train_pc_o(train_pc_o),
        .train_call_o(train_call_o),
        .train_ret_o(train_ret_o),
        .train_jmp_o(train_jmp_o),
        .full_o(full_o),
        .level_o(level_o),
        .drop_count_o(drop_count_o),
        .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state: queued entries plus debug counters
    ent_t sb[$];
    int   m_drop = 0;
    logic m_err = 1'b0;
    logic p_push = 1'b0;
    logic p_drop = 1'b0;
    logic p_err = 1'b0;
    ent_t p_ent;

    int n_tests = 0;
    int n_fail = 0;

    function automatic void chk(string name, logic [31:0] got,
                                logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endfunction

    // Commit the model effects of the edge just passed, then drive next cycle
    task automatic step(input logic req, input logic tk, input logic ntk,
                        input logic [31:0] src, input logic [31:0] pc,
                        input logic call, input logic ret, input logic jmp,
                        input logic fl, input logic acc);
        int   lvl;
        logic pop;
        logic wf;
        @(posedge clk_i);
        #1;
        if (p_push)
            sb.push_back(p_ent);
        if (p_drop && m_drop < MAXD)
            m_drop++;
        if (p_err)
            m_err = 1'b1;
        lvl    = sb.size();
        pop    = (lvl > 0) && acc && !fl;
        wf     = tk ^ ntk;
        p_push = req && wf && !fl && ((lvl < DEPTH) || pop);
        p_drop = req && wf && !fl && (lvl == DEPTH) && !pop;
        p_err  = req && !wf && !fl;
        p_ent  = '{tk, call, ret, jmp, src, pc};
        branch_request_i      = req;
        branch_is_taken_i     = tk;
        branch_is_not_taken_i = ntk;
        branch_source_i       = src;
        branch_pc_i           = pc;
        branch_is_call_i      = call;
        branch_is_ret_i       = ret;
        branch_is_jmp_i       = jmp;
        flush_i               = fl;
        train_accept_i        = acc;
    endtask

    task automatic idle(input logic acc);
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    task automatic push_nt(input logic [31:0] src, input logic acc);
        step(1'b1, 1'b0, 1'b1, src, src + 32'h4, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    endtask

    // Monitor: compare outputs to the model mid-cycle, pop on handshake
    always @(negedge clk_i) begin
        ent_t e;
        chk("valid", train_valid_o, sb.size() != 0);
        chk("level", level_o, sb.size());
        chk("full", full_o, sb.size() == DEPTH);
        chk("drop_count", drop_count_o, m_drop);
        chk("error", error_o, m_err);
        if (sb.size() != 0) begin
            e = sb[0];
            chk("head_taken", train_taken_o, e.tk);
            chk("head_call", train_call_o, e.tk & e.call);
            chk("head_ret", train_ret_o, e.tk & e.ret);
            chk("head_jmp", train_jmp_o, e.tk & e.jmp);
            chk("head_source", train_source_o, e.src);
            chk("head_pc", train_pc_o, e.pc);
        end else begin
            chk("idle_fields", {train_taken_o, train_call_o, train_ret_o,
                                train_jmp_o}, 0);
            chk("idle_source", train_source_o, 0);
            chk("idle_pc", train_pc_o, 0);
        end
        if (flush_i)
            sb.delete();
        else if (sb.size() != 0 && train_accept_i)
            void'(sb.pop_front());
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp3 [4];
        logic        mtk;
        logic        mntk;
        logic        fl;
        #3;
        chk("reset_valid", train_valid_o, 0);
        chk("reset_level", level_o, 0);
        chk("reset_drop", drop_count_o, 0);
        chk("reset_error", error_o, 0);
        #19 rst_i = 1'b0;

        // Single push then accept
        step(1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("single_valid", train_valid_o, 1);
        chk("single_source", train_source_o, 32'h100);
        chk("single_pc", train_pc_o, 32'h200);
        chk("single_call", train_call_o, 1);
        chk("single_level", level_o, 1);
        idle(1'b1);
        idle(1'b0);
        chk("single_pop_valid", train_valid_o, 0);
        chk("single_pop_level", level_o, 0);

        // Fill and overflow
        for (int i = 0; i < 6; i++)
            push_nt(32'h10 + 32'(4 * i), 1'b0);
        idle(1'b0);
        chk("fill_full", full_o, 1);
        chk("fill_level", level_o, 4);
        chk("fill_drop", drop_count_o, 2);
        for (int i = 0; i < 4; i++) begin
            chk("fill_order", train_source_o, 32'h10 + 32'(4 * i));
            idle(1'b1);
            idle(1'b0);
        end
        chk("fill_drained", train_valid_o, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++)
            push_nt(32'h30 + 32'(4 * i), 1'b0);
        idle(1'b0);
        chk("pp_full_before", full_o, 1);
        push_nt(32'h40, 1'b1);
        idle(1'b0);
        chk("pp_level", level_o, 4);
        chk("pp_drop", drop_count_o, 2);
        exp3[0] = 32'h34;
        exp3[1] = 32'h38;
        exp3[2] = 32'h3C;
        exp3[3] = 32'h40;
        for (int i = 0; i < 4; i++) begin
            chk("pp_order", train_source_o, exp3[i]);
            idle(1'b1);
            idle(1'b0);
        end

        // Malformed request and flag gating
        step(1'b1, 1'b1, 1'b1, 32'h77, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("bad_error", error_o, 1);
        chk("bad_level", level_o, 0);
        chk("bad_drop", drop_count_o, 2);
        step(1'b1, 1'b0, 1'b1, 32'h50, 32'h54, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("gate_valid", train_valid_o, 1);
        chk("gate_jmp", train_jmp_o, 0);
        step(1'b1, 1'b1, 1'b0, 32'h58, 32'h900, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(1'b0);
        chk("taken_jmp", train_jmp_o, 1);
        chk("taken_source", train_source_o, 32'h58);
        idle(1'b1);
        idle(1'b0);

        // Flush with a same-cycle request
        for (int i = 0; i < 3; i++)
            push_nt(32'h70 + 32'(4 * i), 1'b0);
        step(1'b1, 1'b1, 1'b0, 32'h99, 32'h9C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        chk("flush_valid", train_valid_o, 0);
        chk("flush_level", level_o, 0);
        chk("flush_drop", drop_count_o, 2);
        step(1'b1, 1'b1, 1'b0, 32'h60, 32'h64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("post_flush_source", train_source_o, 32'h60);
        chk("post_flush_ret", train_ret_o, 1);
        idle(1'b1);
        idle(1'b0);

        // Drop counter saturation
        for (int i = 0; i < 9; i++)
            push_nt(32'hC0 + 32'(4 * i), 1'b0);
        idle(1'b0);
        chk("sat_drop", drop_count_o, MAXD);
        for (int i = 0; i < 4; i++)
            idle(1'b1);
        idle(1'b0);

        // Asynchronous reset between edges
        push_nt(32'hA0, 1'b0);
        push_nt(32'hA4, 1'b0);
        idle(1'b0);
        chk("pre_rst_level", level_o, 2);
        #2 rst_i = 1'b1;
        #1;
        chk("arst_valid", train_valid_o, 0);
        chk("arst_level", level_o, 0);
        chk("arst_full", full_o, 0);
        chk("arst_drop", drop_count_o, 0);
        chk("arst_error", error_o, 0);
        chk("arst_source", train_source_o, 0);
        chk("arst_pc", train_pc_o, 0);
        sb.delete();
        m_drop = 0;
        m_err  = 1'b0;
        p_push = 1'b0;
        p_drop = 1'b0;
        p_err  = 1'b0;
        @(posedge clk_i);
        #2 rst_i = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            mtk  = 1'($urandom_range(0, 1));
            mntk = ~mtk;
            fl   = ($urandom_range(0, 29) == 0);
            if (!fl && $urandom_range(0, 19) == 0)
                mntk = mtk;
            step($urandom_range(0, 99) < 70, mtk, mntk, $urandom, $urandom,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), fl,
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++)
            idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        chk("final_empty", train_valid_o, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
